// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the memory-access stage.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mau_state_e;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_enables(mem_size_e size, logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 4'b0001 << offset;
            SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Store data replicated across every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(mem_size_e size, logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed lane out of a read word and sign/zero-extends it.
module load_aligner
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        unsigned_operation,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension; word accesses pass straight through.
    always_comb begin
        byte_lane = 8'h00;
        case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        value = rdata;
        case (size)
            SIZE_BYTE: value = {{24{~unsigned_operation & byte_lane[7]}}, byte_lane};
            SIZE_HALF: value = {{16{~unsigned_operation & half_lane[15]}}, half_lane};
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access stage: runs one req/ack transaction per load/store, stalls the
// execution stage while waiting, and registers the writeback bundle.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | accepting; non-memory results and decode errors retire here
//  BUSY  | mem_req held, waiting for mem_ack or timeout; freeze asserted
module memory_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int RD_WIDTH       = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid,
    input  logic [31:0]         ALUResult,
    input  logic [31:0]         storeData,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic [1:0]          memSize,
    input  logic                unsigned_operation,
    input  logic [RD_WIDTH-1:0] rdIn,
    input  logic                regWriteIn,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_be,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                wbValid,
    output logic [31:0]         wbData,
    output logic [RD_WIDTH-1:0] wbRd,
    output logic                wbRegWrite,
    output logic                memError,
    output logic                freeze
);

    mau_state_e          state;
    logic [7:0]          tmo_cnt;
    logic [7:0]          tmo_next;
    logic [RD_WIDTH-1:0] cap_rd;
    logic                cap_regwrite;
    mem_size_e           cap_size;
    logic                cap_unsigned;
    logic [1:0]          cap_offset;

    mem_size_e           req_size;
    logic                op_mem;
    logic                misaligned;
    logic                op_error;
    logic [31:0]         load_value;

    assign req_size   = mem_size_e'(memSize);
    assign op_mem     = memRead | memWrite;
    assign misaligned = ((req_size == SIZE_HALF) && ALUResult[0]) ||
                        ((req_size == SIZE_WORD) && (ALUResult[1:0] != 2'b00));
    assign op_error   = (memRead & memWrite) || (req_size == SIZE_ILLEGAL) || misaligned;
    assign tmo_next   = tmo_cnt + 8'd1;

    // Stall is a pure decode of the state register, so it never glitches.
    assign freeze = (state == BUSY);

    load_aligner u_load_aligner (
        .rdata              (mem_rdata),
        .offset             (cap_offset),
        .size               (cap_size),
        .unsigned_operation (cap_unsigned),
        .value              (load_value)
    );

    // Sequencer: accept in IDLE, hold the request in BUSY, retire on ack or timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            tmo_cnt      <= 8'd0;
            cap_rd       <= '0;
            cap_regwrite <= 1'b0;
            cap_size     <= SIZE_BYTE;
            cap_unsigned <= 1'b0;
            cap_offset   <= 2'b00;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_be       <= 4'h0;
            wbValid      <= 1'b0;
            wbData       <= 32'h0;
            wbRd         <= '0;
            wbRegWrite   <= 1'b0;
            memError     <= 1'b0;
        end else begin
            wbValid  <= 1'b0;
            memError <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (!op_mem) begin
                            wbValid    <= 1'b1;
                            wbData     <= ALUResult;
                            wbRd       <= rdIn;
                            wbRegWrite <= regWriteIn;
                        end else if (op_error) begin
                            wbValid    <= 1'b1;
                            memError   <= 1'b1;
                            wbData     <= 32'h0;
                            wbRd       <= rdIn;
                            wbRegWrite <= 1'b0;
                        end else begin
                            state        <= BUSY;
                            tmo_cnt      <= 8'd0;
                            cap_rd       <= rdIn;
                            cap_regwrite <= regWriteIn;
                            cap_size     <= req_size;
                            cap_unsigned <= unsigned_operation;
                            cap_offset   <= ALUResult[1:0];
                            mem_req      <= 1'b1;
                            mem_we       <= memWrite;
                            mem_addr     <= {ALUResult[31:2], 2'b00};
                            // Loads read the whole word, so no lanes are enabled.
                            mem_be       <= memWrite ? byte_enables(req_size, ALUResult[1:0]) : 4'h0;
                            mem_wdata    <= store_lanes(req_size, storeData);
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        wbValid <= 1'b1;
                        wbRd    <= cap_rd;
                        if (mem_we) begin
                            wbData     <= 32'h0;
                            wbRegWrite <= 1'b0;
                        end else begin
                            wbData     <= load_value;
                            wbRegWrite <= cap_regwrite;
                        end
                    end else if (tmo_next == 8'(TIMEOUT_CYCLES)) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        wbValid    <= 1'b1;
                        memError   <= 1'b1;
                        wbData     <= 32'h0;
                        wbRd       <= cap_rd;
                        wbRegWrite <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a writeback scoreboard.
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] ALUResult;
    logic [31:0] storeData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        unsigned_operation;
    logic [4:0]  rdIn;
    logic        regWriteIn;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wbValid;
    logic [31:0] wbData;
    logic [4:0]  wbRd;
    logic        wbRegWrite;
    logic        memError;
    logic        freeze;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        chk_rd;
        logic        rw;
        logic        err;
    } exp_t;

    exp_t sb[$];

    memory_access_unit #(.TIMEOUT_CYCLES(15), .RD_WIDTH(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .valid              (valid),
        .ALUResult          (ALUResult),
        .storeData          (storeData),
        .memRead            (memRead),
        .memWrite           (memWrite),
        .memSize            (memSize),
        .unsigned_operation (unsigned_operation),
        .rdIn               (rdIn),
        .regWriteIn         (regWriteIn),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .wbValid            (wbValid),
        .wbData             (wbData),
        .wbRd               (wbRd),
        .wbRegWrite         (wbRegWrite),
        .memError           (memError),
        .freeze             (freeze)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic [4:0] rd, input logic chk_rd,
                        input logic rw, input logic err);
        exp_t e;
        e.data = data; e.rd = rd; e.chk_rd = chk_rd; e.rw = rw; e.err = err;
        sb.push_back(e);
    endtask

    // Monitor: every writeback pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (memError)
            chk("err_with_wbvalid", {31'b0, wbValid}, 32'd1);
        if (wbValid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {31'b0, wbValid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wbData", wbData, e.data);
                chk("wbRegWrite", {31'b0, wbRegWrite}, {31'b0, e.rw});
                chk("memError", {31'b0, memError}, {31'b0, e.err});
                if (e.chk_rd)
                    chk("wbRd", {27'b0, wbRd}, {27'b0, e.rd});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
        chk({tag, "_wbValid"}, {31'b0, wbValid}, 32'd0);
        chk({tag, "_wbData"}, wbData, 32'd0);
        chk({tag, "_wbRd"}, {27'b0, wbRd}, 32'd0);
        chk({tag, "_wbRegWrite"}, {31'b0, wbRegWrite}, 32'd0);
        chk({tag, "_memError"}, {31'b0, memError}, 32'd0);
        chk({tag, "_freeze"}, {31'b0, freeze}, 32'd0);
    endtask

    // Present one instruction for a single cycle; returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic rd_op,
                         input logic wr_op, input logic [1:0] sz, input logic uns,
                         input logic [4:0] rd, input logic rw);
        chk("freeze_at_accept", {31'b0, freeze}, 32'd0);
        valid = 1'b1; ALUResult = addr; storeData = sdata; memRead = rd_op; memWrite = wr_op;
        memSize = sz; unsigned_operation = uns; rdIn = rd; regWriteIn = rw;
        @(negedge clock);
        valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    endtask

    // Count BUSY cycles, raising mem_ack on the ack_on-th one (0 = never).
    task automatic run_busy(input int ack_on, input logic [31:0] rdata, output int busy);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (!freeze) break;
            busy++;
            mem_ack = (busy == ack_on);
            mem_rdata = rdata;
            @(negedge clock);
        end
        mem_ack = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata, input logic chk_wdata);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd1);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, we});
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, {28'b0, be});
        if (chk_wdata)
            chk({tag, "_mem_wdata"}, mem_wdata, wdata);
        chk({tag, "_freeze"}, {31'b0, freeze}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int busy;
        reset = 1'b1; valid = 1'b0; ALUResult = 32'h0; storeData = 32'h0; memRead = 1'b0;
        memWrite = 1'b0; memSize = 2'b00; unsigned_operation = 1'b0; rdIn = 5'd0;
        regWriteIn = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // pass-through
        push(32'h0000_00C8, 5'd7, 1'b1, 1'b1, 1'b0);
        issue(32'h0000_00C8, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd7, 1'b1);
        chk("pass_freeze", {31'b0, freeze}, 32'd0);
        chk("pass_mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clock);

        // signed byte load at offset 3, ack on third BUSY cycle
        push(32'hFFFF_FF80, 5'd3, 1'b1, 1'b1, 1'b0);
        issue(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 1'b1);
        check_req("lb", 1'b0, 32'h0000_1000, 4'b0000, 32'h0, 1'b0);
        run_busy(3, 32'h80FF_1234, busy);
        chk("lb_busy_cycles", busy, 32'd3);

        // half store at offset 2, immediate ack
        push(32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        issue(32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd9, 1'b1);
        check_req("sh", 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1);
        run_busy(1, 32'h0, busy);
        chk("sh_busy_cycles", busy, 32'd1);

        // unsigned half load at offset 2
        push(32'h0000_9ABC, 5'd10, 1'b1, 1'b1, 1'b0);
        issue(32'h0000_4002, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd10, 1'b1);
        check_req("lhu", 1'b0, 32'h0000_4000, 4'b0000, 32'h0, 1'b0);
        run_busy(2, 32'h9ABC_0000, busy);
        chk("lhu_busy_cycles", busy, 32'd2);

        // misaligned word load: error, no request
        push(32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
        issue(32'h0000_3001, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 1'b1);
        chk("misal_mem_req", {31'b0, mem_req}, 32'd0);
        chk("misal_freeze", {31'b0, freeze}, 32'd0);

        // illegal size and read+write both set
        push(32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
        issue(32'h0000_3000, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 5'd5, 1'b1);
        chk("illegal_mem_req", {31'b0, mem_req}, 32'd0);
        push(32'h0, 5'd6, 1'b0, 1'b0, 1'b1);
        issue(32'h0000_3000, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 5'd6, 1'b1);
        chk("rw_mem_req", {31'b0, mem_req}, 32'd0);

        // byte store at offset 1
        push(32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
        issue(32'h0000_5001, 32'h1234_56A5, 1'b0, 1'b1, 2'b00, 1'b0, 5'd11, 1'b1);
        check_req("sb", 1'b1, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 1'b1);
        run_busy(2, 32'h0, busy);

        // signed half load at offset 0
        push(32'hFFFF_8001, 5'd12, 1'b1, 1'b1, 1'b0);
        issue(32'h0000_5000, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd12, 1'b1);
        run_busy(1, 32'h1234_8001, busy);

        // unsigned byte load at offset 2
        push(32'h0000_00C3, 5'd13, 1'b1, 1'b1, 1'b0);
        issue(32'h0000_5002, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd13, 1'b1);
        run_busy(1, 32'h00C3_0000, busy);

        // word store and word load
        push(32'h0, 5'd14, 1'b1, 1'b0, 1'b0);
        issue(32'h0000_6000, 32'hCAFE_BABE, 1'b0, 1'b1, 2'b10, 1'b0, 5'd14, 1'b1);
        check_req("sw", 1'b1, 32'h0000_6000, 4'b1111, 32'hCAFE_BABE, 1'b1);
        run_busy(1, 32'h0, busy);
        push(32'hCAFE_BABE, 5'd15, 1'b1, 1'b1, 1'b0);
        issue(32'h0000_6000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd15, 1'b1);
        run_busy(4, 32'hCAFE_BABE, busy);
        chk("lw_busy_cycles", busy, 32'd4);

        // timeout: no ack ever
        push(32'h0, 5'd16, 1'b0, 1'b0, 1'b1);
        issue(32'h0000_7000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd16, 1'b1);
        run_busy(0, 32'h0, busy);
        chk("timeout_busy_cycles", busy, 32'd15);
        chk("timeout_mem_req", {31'b0, mem_req}, 32'd0);

        // reset on the fourth BUSY cycle, then a late ack must be ignored
        issue(32'h0000_8000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd17, 1'b1);
        repeat (3) @(negedge clock);
        chk("pre_reset_freeze", {31'b0, freeze}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("midreset");
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        repeat (2) begin
            @(negedge clock);
            chk("late_ack_wbValid", {31'b0, wbValid}, 32'd0);
            chk("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        // recovery after reset
        push(32'h0000_0055, 5'd2, 1'b1, 1'b0, 1'b0);
        issue(32'h0000_0055, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd2, 1'b0);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
